// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM state encoding for the multi-cycle ALU.
// The ALU-control decoder uses the same code constants.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result handshake bundle between ALU-control decode and the multi-cycle ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath; the first iteration runs on the start edge.
// ALU_MUL_EARLY_EXIT_EN: also finish once the shifted multiplier becomes zero.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_a_cur, w_b_cur, w_acc_cur;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt;
  logic [CW-1:0]    w_cnt_cur, w_cnt_nxt;
  logic             w_active, w_last;

  // On start the operands bypass the registers so the accept edge is iteration one.
  assign w_a_cur   = i_start ? i_a : r_a;
  assign w_b_cur   = i_start ? i_b : r_b;
  assign w_acc_cur = i_start ? '0  : r_acc;
  assign w_cnt_cur = i_start ? '0  : r_cnt;

  assign w_acc_nxt = w_acc_cur + (w_b_cur[0] ? w_a_cur : '0);
  assign w_a_nxt   = w_a_cur << 1;
  assign w_b_nxt   = w_b_cur >> 1;
  assign w_cnt_nxt = w_cnt_cur + 1'b1;
  assign w_active  = i_start | i_step;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign w_last = (w_cnt_nxt == CW'(WIDTH)) || (w_b_nxt == '0);
`else
  assign w_last = (w_cnt_nxt == CW'(WIDTH));
`endif

  assign o_done    = w_active && w_last;
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_active) begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR, iterative MUL behind a valid/ready stall.
// Optional macro ALU_MUL_EARLY_EXIT_EN shortens MUL latency; results are unchanged.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_multicycle_if.slave bus
);
  state_t           r_state, w_state_next;
  logic             w_ready, w_accept, w_mul_start, w_mul_step, w_mul_done;
  logic [WIDTH-1:0] w_mul_product, w_single;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .i_start   (w_mul_start),
    .i_step    (w_mul_step),
    .i_a       (bus.data1_i),
    .i_b       (bus.data2_i),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // A MUL that completes on its own accept edge never leaves IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start && !w_mul_done) w_state_next = S_MUL;
      S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == S_IDLE);
    w_accept    = w_ready && bus.valid_i;
    w_mul_start = w_accept && (bus.ALUCtrl_i == ALU_MUL);
    w_mul_step  = (r_state == S_MUL);
  end

  always_comb begin
    w_single = '0;
    case (bus.ALUCtrl_i)
      ALU_ADD: w_single = bus.data1_i + bus.data2_i;
      ALU_SUB: w_single = bus.data1_i - bus.data2_i;
      ALU_AND: w_single = bus.data1_i & bus.data2_i;
      ALU_OR:  w_single = bus.data1_i | bus.data2_i;
      default: w_single = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept && !w_mul_start) begin
        r_data  <= w_single;
        r_valid <= 1'b1;
      end else if (w_mul_done) begin
        r_data  <= w_mul_product;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.zero_o  = (r_data == '0);
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for single-cycle ops, hand sequences for MUL.
// Define ALU_MUL_EARLY_EXIT_EN for both RTL and bench to check the early-exit latency.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    int l;
`ifdef ALU_MUL_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
`else
    l = 32;
`endif
    return l;
  endfunction

  task automatic mul_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int inj);
    int lat, first_v, nv, low, rdy_at_v, hold_bad;
    logic [31:0] d, prev;
    logic z;
    lat = exp_lat(b);
    first_v = -1; nv = 0; low = 0; rdy_at_v = 0; hold_bad = 0; d = '0; z = 1'b0;
    @(negedge clk);
    prev = bus.data_o;
    bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_MUL; bus.data1_i = a; bus.data2_i = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        nv++;
        if (first_v < 0) begin
          first_v = k; d = bus.data_o; z = bus.zero_o; rdy_at_v = int'(bus.ready_o);
        end
      end else if (first_v < 0 && bus.data_o !== prev) begin
        hold_bad++;
      end
      if (!bus.ready_o) low++;
      bus.valid_i = (k == inj);
      if (k == inj) begin
        bus.ALUCtrl_i = ALU_ADD; bus.data1_i = 32'd1; bus.data2_i = 32'd1;
      end
    end
    $display("mul %s: a=%h b=%h data=%h zero=%0d valid_cycle=%0d pulses=%0d ready_low=%0d",
             name, a, b, d, z, first_v, nv, low);
    chk({name, " data"}, d, exp);
    chk({name, " zero"}, 32'(z), 32'(exp == 32'd0));
    chk({name, " valid_cycle"}, 32'(first_v), 32'(lat));
    chk({name, " pulses"}, 32'(nv), 32'd1);
    chk({name, " ready_low"}, 32'(low), 32'(lat - 1));
    chk({name, " ready_at_valid"}, 32'(rdy_at_v), 32'd1);
    chk({name, " hold"}, 32'(hold_bad), 32'd0);
  endtask

  initial begin
    int stray;
    int inj;
    vecs[0] = '{ALU_ADD, 32'd5,        32'd7,        32'd12};
    vecs[1] = '{ALU_SUB, 32'd3,        32'd3,        32'd0};
    vecs[2] = '{ALU_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    vecs[3] = '{ALU_ADD, 32'hFFFF_FFFF, 32'd1,        32'd0};
    vecs[4] = '{ALU_SUB, 32'd0,        32'd1,        32'hFFFF_FFFF};
    vecs[5] = '{ALU_AND, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204};
    vecs[6] = '{ALU_OR,  32'h8000_0000, 32'h0000_0001, 32'h8000_0001};
    vecs[7] = '{3'b101,  32'h1234_5678, 32'h1,        32'd0};
    vecs[8] = '{ALU_ADD, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000};
    vecs[9] = '{3'b111,  32'hDEAD_BEEF, 32'hFFFF,     32'd0};

    bus.valid_i = 1'b0; bus.ALUCtrl_i = ALU_ADD; bus.data1_i = '0; bus.data2_i = '0;

    repeat (2) @(negedge clk);
    $display("reset: ready=%0d valid=%0d data=%h zero=%0d",
             bus.ready_o, bus.valid_o, bus.data_o, bus.zero_o);
    chk("reset ready", 32'(bus.ready_o), 32'd1);
    chk("reset valid", 32'(bus.valid_o), 32'd0);
    chk("reset data", bus.data_o, 32'd0);
    chk("reset zero", 32'(bus.zero_o), 32'd1);
    rst_n = 1'b1;

    // Back-to-back single-cycle requests: each result appears the cycle after its accept.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = 1'b1; bus.ALUCtrl_i = vecs[i].ctrl;
      bus.data1_i = vecs[i].a; bus.data2_i = vecs[i].b;
      @(negedge clk);
      $display("vec %0d: ctrl=%b a=%h b=%h data=%h zero=%0d valid=%0d ready=%0d", i,
               vecs[i].ctrl, vecs[i].a, vecs[i].b, bus.data_o, bus.zero_o, bus.valid_o, bus.ready_o);
      chk($sformatf("vec%0d valid", i), 32'(bus.valid_o), 32'd1);
      chk($sformatf("vec%0d data", i), bus.data_o, vecs[i].exp);
      chk($sformatf("vec%0d zero", i), 32'(bus.zero_o), 32'(vecs[i].exp == 32'd0));
      chk($sformatf("vec%0d ready", i), 32'(bus.ready_o), 32'd1);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    $display("idle: valid=%0d data=%h", bus.valid_o, bus.data_o);
    chk("idle valid", 32'(bus.valid_o), 32'd0);
    chk("idle data hold", bus.data_o, 32'd0);

    mul_case("6x7", 32'd6, 32'd7, 32'd42, 0);
    mul_case("9x0", 32'd9, 32'd0, 32'd0, 0);
    mul_case("2^16sq", 32'h0001_0000, 32'h0001_0000, 32'd0, 0);
    mul_case("m1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
    inj = (exp_lat(32'd5) > 5) ? 5 : exp_lat(32'd5) - 1;
    mul_case("m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, inj);

    // Reset in the middle of a long MUL must abort it without a result pulse.
    stray = 0;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i = 32'd3; bus.data2_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      if (bus.valid_o) stray++;
    end
    rst_n = 1'b0;
    #1;
    $display("midmul reset: ready=%0d valid=%0d data=%h zero=%0d",
             bus.ready_o, bus.valid_o, bus.data_o, bus.zero_o);
    chk("midrst ready", 32'(bus.ready_o), 32'd1);
    chk("midrst valid", 32'(bus.valid_o), 32'd0);
    chk("midrst data", bus.data_o, 32'd0);
    chk("midrst zero", 32'(bus.zero_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (bus.valid_o) stray++;
    end
    $display("post-reset idle: stray_pulses=%0d", stray);
    chk("midrst no pulse", 32'(stray), 32'd0);

    bus.valid_i = 1'b1; bus.ALUCtrl_i = ALU_ADD; bus.data1_i = 32'd1; bus.data2_i = 32'd1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    $display("add after reset: data=%h valid=%0d", bus.data_o, bus.valid_o);
    chk("post-rst add valid", 32'(bus.valid_o), 32'd1);
    chk("post-rst add data", bus.data_o, 32'd2);
    @(negedge clk);
    chk("post-rst single pulse", 32'(bus.valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
